// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: hex glyph table and segment bit positions shared by the
// seven_seg_mux display driver and its glyph decoder.
package seven_seg_pkg;

   localparam int unsigned SEG_A  = 7;
   localparam int unsigned SEG_B  = 6;
   localparam int unsigned SEG_C  = 5;
   localparam int unsigned SEG_D  = 4;
   localparam int unsigned SEG_E  = 3;
   localparam int unsigned SEG_F  = 2;
   localparam int unsigned SEG_G  = 1;
   localparam int unsigned SEG_DP = 0;

   // Active-high a..g, bit 6 = a, bit 0 = g.
   localparam logic [6:0] GLYPH_TAB [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
      return GLYPH_TAB[nib];
   endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// seven_seg_glyph: combinational nibble + decimal point to 8-bit segment code,
// active-high; output polarity is applied by the caller.
module seven_seg_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg                = '0;
      seg[SEG_A:SEG_G]   = hex_to_glyph(nibble);
      seg[SEG_DP]        = dp;
   end

endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: N-digit time-multiplexed 7-segment driver with double-buffered,
// frame-synchronous loading. Optional PWM dimming when SEVEN_SEG_DIM_EN is defined.
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 4096,
   parameter int unsigned BLANK_CYC   = 16,
   parameter int unsigned SEG_ACT_LOW = 1,
   parameter int unsigned SEL_ACT_LOW = 1
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
`ifdef SEVEN_SEG_DIM_EN
   input  logic [3:0]            bright,
`endif
   output logic                  load_ack,
   output logic [7:0]            segm,
   output logic [DIGITS-1:0]     segm_sel
);

   localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW != 0}};
   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACT_LOW != 0}};

   logic [SLOT_W-1:0]   slot_cnt, slot_nxt;
   logic [IDX_W-1:0]    dig_idx, dig_nxt;
   logic                slot_wrap, frame_end, commit;

   logic [4*DIGITS-1:0] act_data, pend_data, act_data_nxt;
   logic [DIGITS-1:0]   act_dp, pend_dp, act_dp_nxt;
   logic [DIGITS-1:0]   act_blank, pend_blank, act_blank_nxt;
   logic                pend_vld;

   logic [3:0]          nib;
   logic                nib_dp, lit, pwm_on;
   logic [7:0]          glyph_seg, seg_hi;
   logic [DIGITS-1:0]   sel_hi;

   assign slot_wrap = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
   assign frame_end = slot_wrap && (dig_idx == IDX_W'(DIGITS - 1));
   assign commit    = frame_end && pend_vld;

   always_comb begin
      slot_nxt = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      dig_nxt  = dig_idx;
      if (slot_wrap)
         dig_nxt = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
   end

   // Outputs are registered from next-cycle state so segm/segm_sel line up
   // with slot_cnt/dig_idx and a commit is visible from digit 0's first slot.
   always_comb begin
      act_data_nxt  = commit ? pend_data  : act_data;
      act_dp_nxt    = commit ? pend_dp    : act_dp;
      act_blank_nxt = commit ? pend_blank : act_blank;
      nib           = act_data_nxt[{dig_nxt, 2'b00} +: 4];
      nib_dp        = act_dp_nxt[dig_nxt];
   end

`ifdef SEVEN_SEG_DIM_EN
   logic [3:0] pwm_cnt, pwm_nxt, bright_q, bright_nxt;

   always_comb begin
      pwm_nxt    = pwm_cnt + 4'd1;
      bright_nxt = frame_end ? bright : bright_q;
      pwm_on     = (pwm_nxt <= bright_nxt);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt  <= '0;
         bright_q <= '1;
      end else begin
         pwm_cnt  <= pwm_nxt;
         bright_q <= bright_nxt;
      end
   end
`else
   assign pwm_on = 1'b1;
`endif

   seven_seg_glyph u_glyph (
      .nibble (nib),
      .dp     (nib_dp),
      .seg    (glyph_seg)
   );

   always_comb begin
      lit    = (32'(slot_nxt) >= BLANK_CYC) && !act_blank_nxt[dig_nxt] && pwm_on;
      sel_hi = lit ? (DIGITS'(1) << dig_nxt) : '0;
      seg_hi = lit ? glyph_seg : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_cnt   <= '0;
         dig_idx    <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_vld   <= 1'b0;
         load_ack   <= 1'b0;
         segm       <= SEG_OFF;
         segm_sel   <= SEL_OFF;
      end else begin
         slot_cnt  <= slot_nxt;
         dig_idx   <= dig_nxt;
         load_ack  <= commit;
         act_data  <= act_data_nxt;
         act_dp    <= act_dp_nxt;
         act_blank <= act_blank_nxt;
         // A load on the commit cycle refills pending after the old value moves out.
         if (load) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_blank <= blank;
            pend_vld   <= 1'b1;
         end else if (commit) begin
            pend_vld   <= 1'b0;
         end
         segm     <= seg_hi ^ SEG_OFF;
         segm_sel <= sel_hi ^ SEL_OFF;
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: scoreboard bench for seven_seg_mux (4 digits, 8-cycle slots,
// 2-cycle blanking gap) with a frame/slot arithmetic reference model.
module tb_seven_seg_mux;

   localparam int unsigned N     = 4;
   localparam int unsigned DIV   = 8;
   localparam int unsigned BLK   = 2;
   localparam int unsigned FRAME = N * DIV;

   logic        clk, reset, load, load_ack;
   logic [15:0] data;
   logic [3:0]  dp, blank, segm_sel;
   logic [7:0]  segm;

   seven_seg_mux #(
      .DIGITS      (N),
      .REFRESH_DIV (DIV),
      .BLANK_CYC   (BLK),
      .SEG_ACT_LOW (1),
      .SEL_ACT_LOW (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .data     (data),
      .dp       (dp),
      .blank    (blank),
`ifdef SEVEN_SEG_DIM_EN
      .bright   (4'hF),
`endif
      .load_ack (load_ack),
      .segm     (segm),
      .segm_sel (segm_sel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ack;
      logic [7:0] segm;
      logic [3:0] sel;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] ref_glyph [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   int unsigned t;
   logic [15:0] m_data, p_data;
   logic [3:0]  m_dp, m_blank, p_dp, p_blank;
   logic        p_vld;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          acks     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] seg_al(input logic [6:0] g, input logic d);
      return ~{g, d};
   endfunction

   // Reference model: t = clock edges since reset release; commits happen on
   // edges that close a frame, then the lit digit is derived from t directly.
   always @(posedge clk or negedge reset) begin : model
      exp_t        e;
      int unsigned slot, dg;
      logic        lit;
      if (!reset) begin
         t       = 0;
         m_data  = '0; m_dp = '0; m_blank = '0;
         p_data  = '0; p_dp = '0; p_blank = '0;
         p_vld   = 1'b0;
         exp_q.delete();
      end else begin
         t++;
         e.ack = 1'b0;
         if ((t % FRAME) == 0 && p_vld) begin
            m_data  = p_data;
            m_dp    = p_dp;
            m_blank = p_blank;
            p_vld   = 1'b0;
            e.ack   = 1'b1;
         end
         if (load) begin
            p_data  = data;
            p_dp    = dp;
            p_blank = blank;
            p_vld   = 1'b1;
         end
         slot   = t % DIV;
         dg     = (t / DIV) % N;
         lit    = (slot >= BLK) && !m_blank[dg];
         e.sel  = lit ? ~(4'b0001 << dg) : 4'hF;
         e.segm = lit ? seg_al(ref_glyph[m_data[dg*4 +: 4]], m_dp[dg]) : 8'hFF;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("load_ack", {31'b0, load_ack}, {31'b0, e.ack});
         check("segm", {24'b0, segm}, {24'b0, e.segm});
         check("segm_sel", {28'b0, segm_sel}, {28'b0, e.sel});
         check("sel_onehot", {31'b0, ($countones(~segm_sel) <= 1)}, 32'd1);
         if (load_ack === 1'b1) acks++;
      end
   end

   task automatic cycles(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int unsigned p);
      for (int i = 0; i < 2 * FRAME && (t % FRAME) != p; i++) @(negedge clk);
      check("reach_phase", t % FRAME, p);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 3 * FRAME && load_ack !== 1'b1; i++) @(negedge clk);
      check("ack_seen", {31'b0, load_ack}, 32'd1);
   endtask

   task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      data  = d;
      dp    = p;
      blank = b;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; load = 1'b0;
      data = '0; dp = '0; blank = '0;
      #2 reset = 1'b0;
      #10;
      check("rst_segm", {24'b0, segm}, 32'hFF);
      check("rst_sel", {28'b0, segm_sel}, 32'hF);
      check("rst_ack", {31'b0, load_ack}, 32'd0);

      // First load right at reset release
      reset = 1'b1;
      data  = 16'h1234;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      wait_ack();
      check("first_ack_cycle", t, 32);
      wait_phase(4);
      check("d0_glyph4", {24'b0, segm}, {24'b0, seg_al(7'h33, 1'b0)});
      check("d0_sel", {28'b0, segm_sel}, 32'hE);
      wait_phase(9);
      check("gap_sel", {28'b0, segm_sel}, 32'hF);
      wait_phase(10);
      check("d1_sel", {28'b0, segm_sel}, 32'hD);

      // Blank and dp masks
      pulse_load(16'hABCD, 4'b0001, 4'b0100);
      wait_ack();
      wait_phase(4);
      check("d0_D_dp", {24'b0, segm}, {24'b0, seg_al(7'h3D, 1'b1)});
      check("d0_sel_b", {28'b0, segm_sel}, 32'hE);
      wait_phase(20);
      check("d2_blank_sel", {28'b0, segm_sel}, 32'hF);
      check("d2_blank_segm", {24'b0, segm}, 32'hFF);
      wait_phase(28);
      check("d3_A", {24'b0, segm}, {24'b0, seg_al(7'h77, 1'b0)});
      check("d3_sel", {28'b0, segm_sel}, 32'h7);

      // Two loads in one frame: last wins, single ack
      wait_phase(2);
      acks = 0;
      pulse_load(16'h1111, 4'b0000, 4'b0000);
      wait_phase(10);
      pulse_load(16'h2222, 4'b0000, 4'b0000);
      cycles(70);
      check("one_ack", acks, 1);
      wait_phase(12);
      check("d1_2", {24'b0, segm}, {24'b0, seg_al(7'h6D, 1'b0)});

      // Load on the boundary cycle
      wait_phase(5);
      pulse_load(16'h3333, 4'b0000, 4'b0000);
      acks = 0;
      wait_phase(31);
      pulse_load(16'h4444, 4'b0000, 4'b0000);
      cycles(40);
      check("boundary_acks", acks, 2);
      wait_phase(4);
      check("d0_4", {24'b0, segm}, {24'b0, seg_al(7'h33, 1'b0)});

      // Randomized loads
      for (int i = 0; i < 320; i++) begin
         load  = ($urandom_range(0, 7) == 0);
         data  = 16'($urandom);
         dp    = 4'($urandom);
         blank = 4'($urandom);
         @(negedge clk);
      end
      load = 1'b0;
      cycles(FRAME + 2);

      // Reset mid-slot of digit 2 with a value still pending
      wait_phase(3);
      pulse_load(16'h5678, 4'b0000, 4'b0000);
      wait_ack();
      wait_phase(3);
      pulse_load(16'h9999, 4'b0000, 4'b0000);
      wait_phase(20);
      check("pre_rst_sel", {28'b0, segm_sel}, 32'hB);
      #2 reset = 1'b0;
      #1;
      check("async_rst_segm", {24'b0, segm}, 32'hFF);
      check("async_rst_sel", {28'b0, segm_sel}, 32'hF);
      check("async_rst_ack", {31'b0, load_ack}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      acks = 0;
      wait_phase(2);
      check("post_rst_d0", {24'b0, segm}, {24'b0, seg_al(7'h7E, 1'b0)});
      check("post_rst_sel", {28'b0, segm_sel}, 32'hE);
      cycles(70);
      check("pending_lost", acks, 0);

      cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
